// File: rtl/mips_defs_pkg.sv
// Shared ISA, ALU, state and datapath-select encodings for the multi-cycle MIPS-subset CPU.
package mips_defs_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_XOR  = 3'd2,
        ALU_SLT  = 3'd3,
        ALU_AND  = 3'd4,
        ALU_OR   = 3'd5,
        ALU_NOR  = 3'd6,
        ALU_PASS = 3'd7
    } alu_op_e;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEMACC = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_RS     = 2'd3
    } pc_src_e;

    typedef enum logic [1:0] {
        SRCB_RT   = 2'd0,
        SRCB_SEXT = 2'd1,
        SRCB_ZEXT = 2'd2,
        SRCB_FOUR = 2'd3
    } src_b_e;

    typedef enum logic [1:0] {
        DST_RT  = 2'd0,
        DST_RD  = 2'd1,
        DST_R31 = 2'd2
    } reg_dst_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MDR = 2'd1,
        WB_PC  = 2'd2
    } wb_sel_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter for memory requests; flags when the next low mem_ready cycle must trap.
module mem_wait_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic count_en,
    output logic limit_reached
);

    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n || clear)
            count <= 8'd0;
        else if (count_en)
            count <= count + 8'd1;
    end

    assign limit_reached = (count == LAST);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencing FSM: drives datapath enables/selects and the shared-memory handshake.
module multicycle_controller
    import mips_defs_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_re,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic [2:0] alu_op,
    output logic [1:0] alu_src_b,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] wb_sel,
    output logic       instr_done,
    output logic       fault
);

    state_e  state, state_next;
    alu_op_e exec_alu;
    src_b_e  exec_src_b;
    logic    is_r_alu, is_jr, is_branch, is_mem, is_valid;
    logic    wait_state, limit_reached;

    assign is_r_alu  = (opcode == OP_RTYPE) &&
                       (funct == FN_ADD || funct == FN_SUB || funct == FN_SLT);
    assign is_jr     = (opcode == OP_RTYPE) && (funct == FN_JR);
    assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign is_mem    = (opcode == OP_LW) || (opcode == OP_SW);
    assign is_valid  = is_r_alu || is_branch || is_mem ||
                       (opcode == OP_ADDI) || (opcode == OP_XORI);

    // The counter only runs while a request is outstanding; any other cycle rearms it.
    assign wait_state = (state == S_FETCH) || (state == S_MEMACC);

    mem_wait_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear         (!wait_state || mem_ready),
        .count_en      (wait_state && !mem_ready),
        .limit_reached (limit_reached)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_FETCH;
            fault <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next == S_TRAP)
                fault <= 1'b1;
        end
    end

    // ALU setup shared by EXEC and WB so the result stays stable through write-back.
    always_comb begin
        exec_alu   = ALU_ADD;
        exec_src_b = SRCB_RT;
        case (opcode)
            OP_RTYPE: begin
                if (funct == FN_SUB)
                    exec_alu = ALU_SUB;
                else if (funct == FN_SLT)
                    exec_alu = ALU_SLT;
            end
            OP_ADDI, OP_LW, OP_SW: exec_src_b = SRCB_SEXT;
            OP_XORI: begin
                exec_alu   = ALU_XOR;
                exec_src_b = SRCB_ZEXT;
            end
            OP_BEQ, OP_BNE: exec_alu = ALU_SUB;
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PC_PLUS4;
        alu_op     = ALU_ADD;
        alu_src_b  = SRCB_RT;
        reg_we     = 1'b0;
        reg_dst    = DST_RT;
        wb_sel     = WB_ALU;
        instr_done = 1'b0;
        case (state)
            S_FETCH: begin
                mem_re    = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_we      = 1'b1;
                    pc_we      = 1'b1;
                    state_next = S_DECODE;
                end else if (limit_reached) begin
                    state_next = S_TRAP;
                end
            end
            S_DECODE: begin
                if (opcode == OP_J || opcode == OP_JAL) begin
                    pc_we      = 1'b1;
                    pc_src     = PC_JUMP;
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                    if (opcode == OP_JAL) begin
                        reg_we  = 1'b1;
                        reg_dst = DST_R31;
                        wb_sel  = WB_PC;
                    end
                end else if (is_jr) begin
                    pc_we      = 1'b1;
                    pc_src     = PC_RS;
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end else if (is_valid) begin
                    state_next = S_EXEC;
                end else begin
                    state_next = S_TRAP;
                end
            end
            S_EXEC: begin
                alu_op    = exec_alu;
                alu_src_b = exec_src_b;
                if (is_branch) begin
                    pc_src     = PC_BRANCH;
                    pc_we      = (opcode == OP_BEQ) ? alu_zero : !alu_zero;
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end else if (is_mem) begin
                    state_next = S_MEMACC;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEMACC: begin
                addr_sel = 1'b1;
                mem_re   = (opcode == OP_LW);
                mem_we   = (opcode == OP_SW);
                if (mem_ready) begin
                    if (opcode == OP_LW) begin
                        state_next = S_WB;
                    end else begin
                        instr_done = 1'b1;
                        state_next = S_FETCH;
                    end
                end else if (limit_reached) begin
                    state_next = S_TRAP;
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                instr_done = 1'b1;
                alu_op     = exec_alu;
                alu_src_b  = exec_src_b;
                if (opcode == OP_RTYPE)
                    reg_dst = DST_RD;
                else if (opcode == OP_LW)
                    wb_sel = WB_MDR;
                state_next = S_FETCH;
            end
            S_TRAP:  state_next = S_TRAP;
            default: state_next = S_TRAP;
        endcase
        // Reset must silence every strobe before the clock edge takes effect.
        if (!reset_n) begin
            mem_re     = 1'b0;
            mem_we     = 1'b0;
            addr_sel   = 1'b0;
            ir_we      = 1'b0;
            pc_we      = 1'b0;
            pc_src     = PC_PLUS4;
            alu_op     = ALU_ADD;
            alu_src_b  = SRCB_RT;
            reg_we     = 1'b0;
            reg_dst    = DST_RT;
            wb_sel     = WB_ALU;
            instr_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: each driven cycle queues its expected outputs; a negedge monitor compares them.
module tb_multicycle_controller;

    typedef struct packed {
        logic       mem_re;
        logic       mem_we;
        logic       addr_sel;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic [2:0] alu_op;
        logic [1:0] alu_src_b;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] wb_sel;
        logic       instr_done;
        logic       fault;
    } out_t;

    typedef struct {
        string tag;
        out_t  val;
        out_t  mask;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] opcode, funct;
    logic       alu_zero, mem_ready;
    logic       mem_re, mem_we, addr_sel, ir_we, pc_we, reg_we, instr_done, fault;
    logic [1:0] pc_src, alu_src_b, reg_dst, wb_sel;
    logic [2:0] alu_op;
    out_t       act;
    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;

    multicycle_controller #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_re(mem_re), .mem_we(mem_we),
        .addr_sel(addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .alu_op(alu_op), .alu_src_b(alu_src_b), .reg_we(reg_we), .reg_dst(reg_dst),
        .wb_sel(wb_sel), .instr_done(instr_done), .fault(fault)
    );

    always #5 clk = ~clk;

    assign act = {mem_re, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_op, alu_src_b,
                  reg_we, reg_dst, wb_sel, instr_done, fault};

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput(e.tag, {13'd0, act & e.mask}, {13'd0, e.val & e.mask});
        end
    end

    // Strobes and fault are always checked; selects only where the cycle defines them.
    function automatic exp_t base();
        exp_t e;
        e.tag = "";
        e.val = '0;
        e.mask = '0;
        e.mask.mem_re = 1; e.mask.mem_we = 1; e.mask.ir_we = 1; e.mask.pc_we = 1;
        e.mask.reg_we = 1; e.mask.instr_done = 1; e.mask.fault = 1;
        return e;
    endfunction

    function automatic exp_t e_fetch(input logic ready);
        exp_t e = base();
        e.val.mem_re = 1; e.mask.addr_sel = 1;
        e.val.alu_src_b = 2'd3; e.mask.alu_src_b = 2'b11; e.mask.alu_op = 3'b111;
        if (ready) begin
            e.val.ir_we = 1; e.val.pc_we = 1; e.mask.pc_src = 2'b11;
        end
        return e;
    endfunction

    function automatic exp_t e_alu(input logic [2:0] op, input logic [1:0] srcb);
        exp_t e = base();
        e.val.alu_op = op; e.mask.alu_op = 3'b111;
        e.val.alu_src_b = srcb; e.mask.alu_src_b = 2'b11;
        return e;
    endfunction

    function automatic exp_t e_mem(input logic is_lw);
        exp_t e = base();
        e.val.addr_sel = 1; e.mask.addr_sel = 1;
        if (is_lw) e.val.mem_re = 1; else e.val.mem_we = 1;
        return e;
    endfunction

    function automatic exp_t e_trap();
        exp_t e = base();
        e.val.fault = 1;
        return e;
    endfunction

    function automatic exp_t e_reset();
        exp_t e = base();
        e.mask = '1;
        e.mask.fault = 0;
        return e;
    endfunction

    task automatic applyStimulus(input string tag, input logic rst, input logic [5:0] op,
                                 input logic [5:0] fn, input logic zero, input logic ready,
                                 input exp_t e);
        reset_n = rst; opcode = op; funct = fn; alu_zero = zero; mem_ready = ready;
        e.tag = tag;
        sb.push_back(e);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus("reset", 1'b0, 6'h00, 6'h00, 1'b0, 1'b1, e_reset());
    endtask

    // Reference sequence for one instruction, derived from its opcode/funct class.
    task automatic runInstr(input string name, input logic [5:0] op, input logic [5:0] fn,
                            input logic zero, input int fetch_waits, input int mem_waits);
        exp_t e;
        logic [2:0] aop;
        logic [1:0] srcb;
        logic is_lw, is_wb;
        logic [1:0] dst, wsel;
        for (int i = 0; i < fetch_waits; i++)
            applyStimulus($sformatf("%s_fwait%0d", name, i), 1, op, fn, zero, 0, e_fetch(0));
        applyStimulus({name, "_fetch"}, 1, op, fn, zero, 1, e_fetch(1));
        if (op == 6'h02 || op == 6'h03 || (op == 6'h00 && fn == 6'h08)) begin
            e = base();
            e.val.pc_we = 1; e.val.instr_done = 1; e.mask.pc_src = 2'b11;
            e.val.pc_src = (op == 6'h00) ? 2'd3 : 2'd2;
            if (op == 6'h03) begin
                e.val.reg_we = 1; e.val.reg_dst = 2'd2; e.val.wb_sel = 2'd2;
                e.mask.reg_dst = 2'b11; e.mask.wb_sel = 2'b11;
            end
            applyStimulus({name, "_decode"}, 1, op, fn, zero, 1, e);
            return;
        end
        applyStimulus({name, "_decode"}, 1, op, fn, zero, 1, base());
        is_wb = 1; is_lw = 0; dst = 2'd0; wsel = 2'd0; aop = 3'd0; srcb = 2'd1;
        case (op)
            6'h00: begin
                srcb = 2'd0; dst = 2'd1;
                case (fn)
                    6'h20: aop = 3'd0;
                    6'h22: aop = 3'd1;
                    6'h2A: aop = 3'd3;
                    default: is_wb = 0;
                endcase
            end
            6'h08: ;
            6'h0E: begin aop = 3'd2; srcb = 2'd2; end
            6'h23: begin is_lw = 1; wsel = 2'd1; end
            6'h2B: is_wb = 0;
            6'h04, 6'h05: begin
                e = e_alu(3'd1, 2'd0);
                e.val.pc_src = 2'd1; e.mask.pc_src = 2'b11; e.val.instr_done = 1;
                e.val.pc_we = (op == 6'h04) ? zero : !zero;
                applyStimulus({name, "_exec"}, 1, op, fn, zero, 1, e);
                return;
            end
            default: is_wb = 0;
        endcase
        if (!is_wb && op != 6'h2B) begin
            applyStimulus({name, "_trap0"}, 1, op, fn, zero, 1, e_trap());
            applyStimulus({name, "_trap1"}, 1, op, fn, zero, 0, e_trap());
            return;
        end
        applyStimulus({name, "_exec"}, 1, op, fn, zero, 1, e_alu(aop, srcb));
        if (op == 6'h23 || op == 6'h2B) begin
            for (int i = 0; i < mem_waits; i++)
                applyStimulus($sformatf("%s_mwait%0d", name, i), 1, op, fn, zero, 0, e_mem(is_lw));
            e = e_mem(is_lw);
            if (!is_lw) e.val.instr_done = 1;
            applyStimulus({name, "_memdone"}, 1, op, fn, zero, 1, e);
        end
        if (is_wb) begin
            e = e_alu(aop, srcb);
            e.val.reg_we = 1; e.val.instr_done = 1;
            e.val.reg_dst = dst; e.mask.reg_dst = 2'b11;
            e.val.wb_sel = wsel; e.mask.wb_sel = 2'b11;
            applyStimulus({name, "_wb"}, 1, op, fn, zero, 1, e);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog time limit expired");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        reset_n = 0; opcode = 0; funct = 0; alu_zero = 0; mem_ready = 0;
        @(posedge clk);
        #1;
        doReset();
        doReset();

        runInstr("add", 6'h00, 6'h20, 0, 0, 0);
        runInstr("sub", 6'h00, 6'h22, 1, 2, 0);
        runInstr("slt", 6'h00, 6'h2A, 0, 0, 0);
        runInstr("lw", 6'h23, 6'h15, 0, 0, 3);
        runInstr("sw", 6'h2B, 6'h00, 0, 1, 1);
        runInstr("addi", 6'h08, 6'h3F, 0, 0, 0);
        runInstr("xori", 6'h0E, 6'h00, 1, 0, 0);
        runInstr("beq_t", 6'h04, 6'h00, 1, 0, 0);
        runInstr("bne_nt", 6'h05, 6'h00, 1, 0, 0);
        runInstr("beq_nt", 6'h04, 6'h00, 0, 0, 0);
        runInstr("bne_t", 6'h05, 6'h00, 0, 0, 0);
        runInstr("j", 6'h02, 6'h00, 0, 0, 0);
        runInstr("jal", 6'h03, 6'h00, 0, 1, 0);
        runInstr("jr", 6'h00, 6'h08, 0, 0, 0);

        // Fetch never completes: four wait cycles, then an absorbing trap.
        for (int i = 0; i < 4; i++)
            applyStimulus($sformatf("fto_wait%0d", i), 1, 6'h00, 6'h20, 0, 0, e_fetch(0));
        applyStimulus("fto_trap0", 1, 6'h00, 6'h20, 0, 1, e_trap());
        applyStimulus("fto_trap1", 1, 6'h00, 6'h20, 0, 1, e_trap());
        doReset();

        // Ready arriving on the limit cycle wins.
        runInstr("add_lim", 6'h00, 6'h20, 0, 3, 0);

        // Load whose data never arrives.
        applyStimulus("mto_fetch", 1, 6'h23, 6'h00, 0, 1, e_fetch(1));
        applyStimulus("mto_decode", 1, 6'h23, 6'h00, 0, 1, base());
        applyStimulus("mto_exec", 1, 6'h23, 6'h00, 0, 1, e_alu(3'd0, 2'd1));
        for (int i = 0; i < 4; i++)
            applyStimulus($sformatf("mto_wait%0d", i), 1, 6'h23, 6'h00, 0, 0, e_mem(1));
        applyStimulus("mto_trap", 1, 6'h23, 6'h00, 0, 1, e_trap());
        doReset();

        runInstr("bad_op", 6'h3F, 6'h00, 0, 0, 0);
        doReset();
        runInstr("bad_fn", 6'h00, 6'h21, 0, 0, 0);
        doReset();

        // Reset asserted while a store is waiting in MEMACC.
        applyStimulus("rst_fetch", 1, 6'h2B, 6'h00, 0, 1, e_fetch(1));
        applyStimulus("rst_decode", 1, 6'h2B, 6'h00, 0, 1, base());
        applyStimulus("rst_exec", 1, 6'h2B, 6'h00, 0, 1, e_alu(3'd0, 2'd1));
        applyStimulus("rst_memwait", 1, 6'h2B, 6'h00, 0, 0, e_mem(0));
        applyStimulus("rst_low", 0, 6'h2B, 6'h00, 0, 0, e_reset());
        runInstr("sw_after", 6'h2B, 6'h00, 0, 0, 0);

        @(negedge clk);
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
